// File: rtl/vic_vector_ctrl.sv
// ----------------------------------------------------------------------------
// vic_vector_ctrl
// Vectored interrupt controller back end. Holds a 31-entry vector table,
// captures the winning interrupt from the prioritiser, raises a level
// request to the CPU, waits for acknowledge (with a bounded timeout), then
// stays in service until end-of-interrupt.
//
// Ports
//   i_clk         clock, all state on rising edge
//   i_rst         asynchronous active-low reset
//   i_irq_req     one-cycle request pulse from the prioritiser
//   i_irq_addr    winning interrupt number (0..30), valid with i_irq_req
//   i_wr_en       vector-table write strobe
//   i_wr_addr     vector-table write index (31 is ignored)
//   i_wr_data     vector-table write data
//   i_cpu_ack     CPU has fetched the vector
//   i_cpu_eoi     end of interrupt
//   i_clr_status  clears o_timeout and o_drop_cnt
//   o_cpu_irq     level interrupt request to the CPU
//   o_vector      handler address of the held interrupt
//   o_irq_num     number of the held interrupt
//   o_in_service  busy back to the prioritiser
//   o_timeout     sticky acknowledge-timeout flag
//   o_drop_cnt    saturating count of rejected requests
// ----------------------------------------------------------------------------
module vic_vector_ctrl #(
    parameter int VEC_W       = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_irq_req,
    input  logic [4:0]       i_irq_addr,
    input  logic             i_wr_en,
    input  logic [4:0]       i_wr_addr,
    input  logic [VEC_W-1:0] i_wr_data,
    input  logic             i_cpu_ack,
    input  logic             i_cpu_eoi,
    input  logic             i_clr_status,
    output logic             o_cpu_irq,
    output logic [VEC_W-1:0] o_vector,
    output logic [4:0]       o_irq_num,
    output logic             o_in_service,
    output logic             o_timeout,
    output logic [7:0]       o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_SERV = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LOAD = 8'(ACK_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_tmo;
    logic [VEC_W-1:0] r_table [0:30];
    logic [VEC_W-1:0] r_vector;
    logic [4:0]       r_irq_num;
    logic             r_timeout;
    logic [7:0]       r_drop_cnt;

    logic             w_capture;
    logic             w_drop;
    logic             w_expire;

    // Next-state and event decode
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_drop    = 1'b0;
        w_expire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_irq_req) begin
                    if (i_irq_addr != 5'd31) begin
                        w_capture = 1'b1;
                        w_next    = S_PEND;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_PEND: begin
                w_drop = i_irq_req;
                // Acknowledge beats an expiry landing in the same cycle.
                if (i_cpu_ack) begin
                    w_next = S_SERV;
                end else if (r_tmo == 8'd1) begin
                    w_next   = S_IDLE;
                    w_expire = 1'b1;
                end
            end
            S_SERV: begin
                // A request coinciding with eoi is still rejected.
                w_drop = i_irq_req;
                if (i_cpu_eoi) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Acknowledge timeout counter: expiry is the PEND cycle where it reads 1,
    // giving exactly ACK_TIMEOUT PEND cycles before returning to IDLE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tmo <= 8'd0;
        end else if (w_capture) begin
            r_tmo <= TMO_LOAD;
        end else if (r_state == S_PEND && r_tmo != 8'd0) begin
            r_tmo <= r_tmo - 8'd1;
        end
    end

    // Vector table; the capture reads the pre-edge value, so a same-cycle
    // write to the captured entry is not visible until the next capture.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 31; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wr_en && i_wr_addr != 5'd31) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vector  <= '0;
            r_irq_num <= 5'd0;
        end else if (w_capture) begin
            r_vector  <= r_table[i_irq_addr];
            r_irq_num <= i_irq_addr;
        end
    end

    // Status: clear has priority over a simultaneous set/increment.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_timeout  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (i_clr_status) begin
            r_timeout  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            if (w_drop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign o_cpu_irq    = (r_state == S_PEND);
    assign o_in_service = (r_state != S_IDLE);
    assign o_vector     = r_vector;
    assign o_irq_num    = r_irq_num;
    assign o_timeout    = r_timeout;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_vic_vector_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vic_vector_ctrl
// Directed-vector bench for vic_vector_ctrl with ACK_TIMEOUT=4. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_vic_vector_ctrl;

    localparam int VEC_W = 32;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_irq_req;
    logic [4:0]       i_irq_addr;
    logic             i_wr_en;
    logic [4:0]       i_wr_addr;
    logic [VEC_W-1:0] i_wr_data;
    logic             i_cpu_ack;
    logic             i_cpu_eoi;
    logic             i_clr_status;
    logic             o_cpu_irq;
    logic [VEC_W-1:0] o_vector;
    logic [4:0]       o_irq_num;
    logic             o_in_service;
    logic             o_timeout;
    logic [7:0]       o_drop_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    vic_vector_ctrl #(
        .VEC_W       (VEC_W),
        .ACK_TIMEOUT (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_irq_req    (i_irq_req),
        .i_irq_addr   (i_irq_addr),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_cpu_ack    (i_cpu_ack),
        .i_cpu_eoi    (i_cpu_eoi),
        .i_clr_status (i_clr_status),
        .o_cpu_irq    (o_cpu_irq),
        .o_vector     (o_vector),
        .o_irq_num    (o_irq_num),
        .o_in_service (o_in_service),
        .o_timeout    (o_timeout),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_irq_req    = 1'b0;
        i_irq_addr   = 5'd0;
        i_wr_en      = 1'b0;
        i_wr_addr    = 5'd0;
        i_wr_data    = '0;
        i_cpu_ack    = 1'b0;
        i_cpu_eoi    = 1'b0;
        i_clr_status = 1'b0;
    endtask

    task automatic req(input logic [4:0] a);
        i_irq_req = 1'b1; i_irq_addr = a;
        tick();
        i_irq_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic ack();
        i_cpu_ack = 1'b1;
        tick();
        i_cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        i_cpu_eoi = 1'b1;
        tick();
        i_cpu_eoi = 1'b0;
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b0;
        #12;
        // reset state
        chk("rst_cpu_irq", 32'(o_cpu_irq), 32'd0);
        chk("rst_in_svc",  32'(o_in_service), 32'd0);
        chk("rst_vector",  o_vector, 32'd0);
        chk("rst_irq_num", 32'(o_irq_num), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_drop",    32'(o_drop_cnt), 32'd0);
        i_rst = 1'b1;
        tick();

        // ack in IDLE is ignored
        ack();
        chk("idle_ack_in_svc", 32'(o_in_service), 32'd0);

        // nominal flow
        wr(5'd5, 32'h0000_1040);
        req(5'd5);
        chk("nom_cpu_irq", 32'(o_cpu_irq), 32'd1);
        chk("nom_in_svc",  32'(o_in_service), 32'd1);
        chk("nom_vector",  o_vector, 32'h0000_1040);
        chk("nom_irq_num", 32'(o_irq_num), 32'd5);
        ack();
        chk("nom_ack_cpu_irq", 32'(o_cpu_irq), 32'd0);
        chk("nom_ack_in_svc",  32'(o_in_service), 32'd1);
        // table write while held does not disturb the captured vector
        wr(5'd5, 32'h0000_2222);
        chk("frozen_vector", o_vector, 32'h0000_1040);
        eoi();
        chk("nom_eoi_in_svc", 32'(o_in_service), 32'd0);

        // timeout without ack: 4 PEND cycles
        req(5'd5);
        chk("tmo_vector", o_vector, 32'h0000_2222);
        tick(); tick(); tick();
        chk("tmo_still_pend", 32'(o_cpu_irq), 32'd1);
        tick();
        chk("tmo_cpu_irq", 32'(o_cpu_irq), 32'd0);
        chk("tmo_in_svc",  32'(o_in_service), 32'd0);
        chk("tmo_flag",    32'(o_timeout), 32'd1);
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0;
        chk("tmo_clr", 32'(o_timeout), 32'd0);

        // ack on the expiry cycle wins
        req(5'd5);
        tick(); tick(); tick();
        ack();
        chk("tmo_ack_cpu_irq", 32'(o_cpu_irq), 32'd0);
        chk("tmo_ack_in_svc",  32'(o_in_service), 32'd1);
        chk("tmo_ack_flag",    32'(o_timeout), 32'd0);

        // drops: 3 during SERV, then addr 31 in IDLE
        i_irq_req = 1'b1; i_irq_addr = 5'd1;
        tick(); tick(); tick();
        i_irq_req = 1'b0;
        chk("drop_serv_in_svc", 32'(o_in_service), 32'd1);
        eoi();
        req(5'd31);
        chk("drop_addr31_in_svc", 32'(o_in_service), 32'd0);
        chk("drop_cnt4", 32'(o_drop_cnt), 32'd4);

        // eoi and req in the same cycle: dropped, next-cycle req accepted
        req(5'd5);
        ack();
        i_cpu_eoi = 1'b1; i_irq_req = 1'b1; i_irq_addr = 5'd3;
        tick();
        i_cpu_eoi = 1'b0; i_irq_req = 1'b0;
        chk("eoi_req_in_svc", 32'(o_in_service), 32'd0);
        chk("eoi_req_drop",   32'(o_drop_cnt), 32'd5);
        req(5'd3);
        chk("eoi_next_cpu_irq", 32'(o_cpu_irq), 32'd1);
        chk("eoi_next_irq_num", 32'(o_irq_num), 32'd3);
        ack();
        eoi();

        // saturation
        i_irq_req = 1'b1; i_irq_addr = 5'd31;
        for (int i = 0; i < 300; i++) tick();
        chk("drop_sat", 32'(o_drop_cnt), 32'd255);
        // clear coincident with a drop: clear wins
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0; i_irq_req = 1'b0;
        chk("drop_clr", 32'(o_drop_cnt), 32'd0);

        // write to index 31 ignored (nothing observable breaks, no capture)
        wr(5'd31, 32'hDEAD_BEEF);
        chk("wr31_in_svc", 32'(o_in_service), 32'd0);

        // read/write collision
        wr(5'd7, 32'h0000_1111);
        i_wr_en = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'h0000_AAAA;
        i_irq_req = 1'b1; i_irq_addr = 5'd7;
        tick();
        i_wr_en = 1'b0; i_irq_req = 1'b0;
        chk("coll_old", o_vector, 32'h0000_1111);
        ack();
        eoi();
        req(5'd7);
        chk("coll_new", o_vector, 32'h0000_AAAA);
        ack();

        // reset mid-SERV
        req(5'd9);
        chk("pre_rst_drop", 32'(o_drop_cnt), 32'd1);
        i_rst = 1'b0;
        #2;
        chk("arst_in_svc",  32'(o_in_service), 32'd0);
        chk("arst_cpu_irq", 32'(o_cpu_irq), 32'd0);
        chk("arst_vector",  o_vector, 32'd0);
        chk("arst_irq_num", 32'(o_irq_num), 32'd0);
        chk("arst_drop",    32'(o_drop_cnt), 32'd0);
        i_rst = 1'b1;
        // first edge after release accepts; table[5] was cleared
        req(5'd5);
        chk("post_rst_in_svc", 32'(o_in_service), 32'd1);
        chk("post_rst_vector", o_vector, 32'd0);
        chk("post_rst_irq_num", 32'(o_irq_num), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
